// File: rtl/conv_pkg.sv
// Shared defaults, FSM state encoding and index sizing for the
// truncated-convolution sequencer.
package conv_pkg;

    localparam int N_TAPS_DEF = 9;
    localparam int DW_DEF     = 4;
    localparam int RW_DEF     = 8;
    localparam int IDX_W      = $clog2(N_TAPS_DEF);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Single shared multiply-accumulate: sum = (acc + a*b) mod 2^RW.
module conv_mac_unit #(
    parameter int DW = 4,
    parameter int RW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [RW-1:0] acc,
    output logic [RW-1:0] sum
);

    logic [2*DW-1:0] prod;

    assign prod = a * b;
    assign sum  = acc + RW'(prod);

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for a truncated causal convolution using one time-shared
// multiplier and accumulator; one result element per inner-loop pass.
import conv_pkg::*;

module conv_seq_ctrl #(
    parameter int N_TAPS = N_TAPS_DEF,
    parameter int DW     = DW_DEF,
    parameter int RW     = RW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_TAPS*DW-1:0] a_in,
    input  logic [N_TAPS*DW-1:0] b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_TAPS*RW-1:0] c_out,
    output logic                 busy
);

    localparam int IW = idx_width(N_TAPS);
    localparam logic [IW-1:0] LAST = IW'(N_TAPS - 1);

    state_t         state;
    logic [IW-1:0]  i;
    logic [IW-1:0]  j;
    logic [IW-1:0]  k;
    logic [RW-1:0]  acc;
    logic [RW-1:0]  acc_next;
    logic [DW-1:0]  a_arr [N_TAPS];
    logic [DW-1:0]  b_arr [N_TAPS];
    logic [RW-1:0]  c_arr [N_TAPS];
    logic [DW-1:0]  a_sel;
    logic [DW-1:0]  b_sel;

    assign k     = i - j;
    assign a_sel = a_arr[j];
    assign b_sel = b_arr[k];

    conv_mac_unit #(
        .DW (DW),
        .RW (RW)
    ) u_mac (
        .a   (a_sel),
        .b   (b_sel),
        .acc (acc),
        .sum (acc_next)
    );

    for (genvar g = 0; g < N_TAPS; g++) begin : g_c
        assign c_out[(N_TAPS-1-g)*RW +: RW] = c_arr[g];
    end

    // out_valid rises one cycle after entering DONE, and only then is
    // out_ready honoured, so the handshake always sees a settled result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int n = 0; n < N_TAPS; n++) begin
                a_arr[n] <= '0;
                b_arr[n] <= '0;
                c_arr[n] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int n = 0; n < N_TAPS; n++) begin
                            a_arr[n] <= a_in[(N_TAPS-1-n)*DW +: DW];
                            b_arr[n] <= b_in[(N_TAPS-1-n)*DW +: DW];
                        end
                        i        <= '0;
                        j        <= '0;
                        acc      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    if (j == i) begin
                        c_arr[i] <= acc_next;
                        acc      <= '0;
                        j        <= '0;
                        if (i == LAST) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        acc <= acc_next;
                        j   <= j + 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter N_TAPS, default 9: samples per operand vector and results per output vector.
REQ-002 SHALL have parameter DW, default 4: operand sample width in bits, unsigned.
REQ-003 SHALL have parameter RW, default 8: result element width in bits, unsigned, modulo 2^RW.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: operand pair offered.
REQ-007 SHALL have port in_ready, output, 1: block can accept an operand pair.
REQ-008 SHALL have port a_in, input, N_TAPS*DW: sequence A; element 0 in the MS nibble.
REQ-009 SHALL have port b_in, input, N_TAPS*DW: sequence B; same packing as a_in.
REQ-010 SHALL have port out_valid, output, 1: result vector available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port c_out, output, N_TAPS*RW: results; element 0 in the MS byte.
REQ-013 SHALL have port busy, output, 1: high while in state MAC.

Function
REQ-014 SHALL compute c[i] = (sum over j=0..i of a[j]*b[i-j]) mod 2^RW, for i=0..N_TAPS-1 (truncated causal convolution).
REQ-015 SHALL use exactly one DW x DW multiplier and one RW-bit accumulator, time-shared across all terms.
REQ-016 SHALL implement FSM states IDLE, MAC and DONE.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready, capture a_in/b_in into internal registers, set i=0, j=0, acc=0, go to MAC.
REQ-018 MAC: in_ready=0, busy=1; each cycle compute acc_next = (acc + a[j]*b[i-j]) mod 2^RW.
REQ-019 MAC, j<i: acc<=acc_next and j<=j+1.
REQ-020 MAC, j==i: write c[i]<=acc_next and set acc<=0, j<=0.
REQ-021 MAC, j==i and i<N_TAPS-1: i<=i+1 and stay in MAC.
REQ-022 MAC, j==i and i==N_TAPS-1: go to DONE.
REQ-023 SHALL spend exactly N_TAPS*(N_TAPS+1)/2 cycles in MAC (45 at default).
REQ-024 SHALL assert out_valid exactly 46 cycles after the accepting edge, at default parameters.
REQ-025 DONE: out_valid=1, in_ready=0; c_out stable until accepted.
REQ-026 DONE: on out_ready, go to IDLE; out_valid deasserts next cycle; c_out keeps its value.
REQ-027 SHALL ignore in_valid, a_in and b_in outside IDLE; there is no operand overlap with compute or drain.
REQ-028 SHALL ignore out_ready outside DONE.
REQ-029 Intermediate sums SHALL wrap silently, with no saturation or overflow flag (max unwrapped sum is 2025 at default).
REQ-030 c_out elements SHALL update only when written per REQ-020; unwritten elements keep their prior values during MAC.

Reset
REQ-031 When rst=1 at a clock edge, the FSM SHALL go to IDLE, regardless of current state, including mid-MAC or in DONE.
REQ-032 On reset, i, j, acc, operand registers and c_out SHALL be cleared to 0.
REQ-033 Outputs after reset SHALL be: in_ready=1, out_valid=0, busy=0, c_out=0.
REQ-034 rst SHALL take priority over any simultaneous in_valid or out_ready.

Structure
REQ-035 Package conv_pkg SHALL hold N_TAPS, DW and RW defaults, the FSM state enum (IDLE, MAC, DONE) and the index width clog2(N_TAPS).
REQ-036 SHALL instantiate one sub-module, conv_mac_unit: combinational a*b + acc, mod 2^RW.
REQ-037 Sample select (a[j], b[i-j]) and result write-enable SHALL live in conv_seq_ctrl.

Verification
REQ-038 Scenario all-ones: all a=1, all b=1 -> c[i]=i+1, so c_out=0x010203040506070809; out_valid at accept+46.
REQ-039 Scenario impulse: a0=1, other a=0, b=0x123456789 -> c_out=0x010203040506070809, i.e. b zero-extended per byte.
REQ-040 Scenario all-fifteens: all a=15, all b=15 -> c[i]=(i+1)*225 mod 256; c[0]=0xE1, c[1]=0xC2, c[8]=0xE9.
REQ-041 Scenario backpressure: out_ready low 10 cycles in DONE -> out_valid held, c_out stable, in_valid pulses ignored; one cycle after out_ready: IDLE, in_ready=1.
REQ-042 Scenario reset mid-MAC: rst high on the 20th MAC cycle -> next cycle in_ready=1, busy=0, out_valid=0, c_out=0; the next transaction then completes correctly.
REQ-043 Scenario back-to-back: in_valid held high with out_ready=1 -> second accept occurs exactly one cycle after the DONE->IDLE transition.
